// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and L2 arbiter state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } l2_arb_state_t;

endpackage

// File: rtl/l2_arbiter_control.sv
// rtl/l2_arbiter_control.sv - L2 ownership FSM and round-robin history bit
module l2_arbiter_control
    import lc3b_types::*;
#(
    parameter int FAIR = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic d_req,
    input  logic l2_resp,
    output logic grant_i,
    output logic grant_d,
    output logic latch_req,
    output logic latch_d,
    output logic done
);

    l2_arb_state_t state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          pick_d;

    // D wins when alone, under fixed priority, or when I was the one served last
    always_comb begin
        pick_d = d_req && (!i_req || (FAIR == 0) || !last_d_q);
    end

    // Next state; the history bit moves only when a transaction completes
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = pick_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_resp) begin
                    state_d  = DONE;
                    last_d_d = (state_q == BUSY_D);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and history registers; last_d resets high so I wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Decoded grants and handshake strobes for the datapath
    always_comb begin
        grant_i   = (state_q == BUSY_I);
        grant_d   = (state_q == BUSY_D);
        latch_req = (state_q == IDLE) && (i_req || d_req);
        latch_d   = pick_d;
        done      = (grant_i || grant_d) && l2_resp;
    end

endmodule

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - shares one L2 between the L1 I-cache and D-cache
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  lc3b_word    i_address,
    input  logic        i_read,
    output lc3b_l1_line i_rdata,
    output logic        i_resp,
    input  lc3b_word    d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  lc3b_l1_line d_wdata,
    output lc3b_l1_line d_rdata,
    output logic        d_resp,
    output lc3b_word    l2_address,
    output lc3b_l1_line l2_wdata,
    output logic        l2_read,
    output logic        l2_write,
    input  lc3b_l1_line l2_rdata,
    input  logic        l2_resp,
    output logic        grant_d
);

    lc3b_word    req_address_q;
    lc3b_l1_line req_wdata_q;
    logic        req_write_q;
    logic        grant_i;
    logic        latch_req;
    logic        latch_d;
    logic        done;

    l2_arbiter_control #(
        .FAIR(FAIR)
    ) u_control (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_read),
        .d_req    (d_read || d_write),
        .l2_resp  (l2_resp),
        .grant_i  (grant_i),
        .grant_d  (grant_d),
        .latch_req(latch_req),
        .latch_d  (latch_d),
        .done     (done)
    );

    // Capture the winner's request so the L2 sees a stable replay; a D request
    // with both strobes set is forwarded as a write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_address_q <= '0;
            req_wdata_q   <= '0;
            req_write_q   <= 1'b0;
        end else if (latch_req) begin
            req_address_q <= latch_d ? d_address : i_address;
            req_wdata_q   <= latch_d ? d_wdata : '0;
            req_write_q   <= latch_d && d_write;
        end
    end

    // L2 request from latched registers, response routed only to the owner
    always_comb begin
        l2_address = req_address_q;
        l2_wdata   = req_wdata_q;
        l2_read    = grant_i || (grant_d && !req_write_q);
        l2_write   = grant_d && req_write_q;
        i_resp     = done && grant_i;
        d_resp     = done && grant_d;
        i_rdata    = grant_i ? l2_rdata : '0;
        d_rdata    = grant_d ? l2_rdata : '0;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - self-checking bench for l2_arbiter (round-robin and fixed-priority instances)
module tb_l2_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // index 0: FAIR=1 instance, index 1: FAIR=0 instance
    logic [15:0]  i_address [2];
    logic         i_read    [2];
    logic [127:0] i_rdata   [2];
    logic         i_resp    [2];
    logic [15:0]  d_address [2];
    logic         d_read    [2];
    logic         d_write   [2];
    logic [127:0] d_wdata   [2];
    logic [127:0] d_rdata   [2];
    logic         d_resp    [2];
    logic [15:0]  l2_address[2];
    logic [127:0] l2_wdata  [2];
    logic         l2_read   [2];
    logic         l2_write  [2];
    logic [127:0] l2_rdata  [2];
    logic         l2_resp   [2];
    logic         grant_d   [2];

    int n_checks = 0;
    int n_fail   = 0;

    l2_arbiter #(.FAIR(1)) dut_fair (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address[0]), .i_read(i_read[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_address(d_address[0]), .d_read(d_read[0]), .d_write(d_write[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .l2_address(l2_address[0]), .l2_wdata(l2_wdata[0]), .l2_read(l2_read[0]), .l2_write(l2_write[0]),
        .l2_rdata(l2_rdata[0]), .l2_resp(l2_resp[0]), .grant_d(grant_d[0])
    );

    l2_arbiter #(.FAIR(0)) dut_prio (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address[1]), .i_read(i_read[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_address(d_address[1]), .d_read(d_read[1]), .d_write(d_write[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .l2_address(l2_address[1]), .l2_wdata(l2_wdata[1]), .l2_read(l2_read[1]), .l2_write(l2_write[1]),
        .l2_rdata(l2_rdata[1]), .l2_resp(l2_resp[1]), .grant_d(grant_d[1])
    );

    typedef struct {
        bit           use_d;
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           lat;
        logic [127:0] line;
        bit           exp_read;
        bit           exp_write;
        bit           exp_gd;
    } vec_t;

    vec_t vecs [5];

    // reference model state, one set per instance
    int           m_owner [2];   // 0 none, 1 I, 2 D
    bit           m_gap   [2];
    bit           m_last_d[2];
    bit           m_wr    [2];
    logic [15:0]  m_addr  [2];
    logic [127:0] m_wdata [2];
    int           m_lat   [2];
    bit           i_pend  [2];
    bit           d_pend  [2];
    bit           i_drop  [2];
    bit           d_drop  [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs(input int k);
        i_read[k]    = 1'b0;
        d_read[k]    = 1'b0;
        d_write[k]   = 1'b0;
        i_address[k] = '0;
        d_address[k] = '0;
        d_wdata[k]   = '0;
        l2_resp[k]   = 1'b0;
        l2_rdata[k]  = '0;
    endtask

    task automatic check_quiet(input int k, input string tag);
        chk({tag, "_l2_read"},  l2_read[k],  1'b0);
        chk({tag, "_l2_write"}, l2_write[k], 1'b0);
        chk({tag, "_grant_d"},  grant_d[k],  1'b0);
        chk({tag, "_i_resp"},   i_resp[k],   1'b0);
        chk({tag, "_d_resp"},   d_resp[k],   1'b0);
        chk({tag, "_i_rdata"},  i_rdata[k],  128'h0);
        chk({tag, "_d_rdata"},  d_rdata[k],  128'h0);
    endtask

    // Single lone transaction on the FAIR=1 instance, starting with the DUT idle
    task automatic run_entry(input int idx, input vec_t v);
        i_read[0]    = !v.use_d;
        i_address[0] = v.addr;
        d_read[0]    = v.use_d && v.rd;
        d_write[0]   = v.use_d && v.wr;
        d_address[0] = v.use_d ? v.addr : 16'h0;
        d_wdata[0]   = v.wdata;
        #1;
        chk($sformatf("vec%0d_no_early_read", idx), l2_read[0] || l2_write[0], 1'b0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_l2_read", idx),  l2_read[0],  v.exp_read);
        chk($sformatf("vec%0d_l2_write", idx), l2_write[0], v.exp_write);
        chk($sformatf("vec%0d_grant_d", idx),  grant_d[0],  v.exp_gd);
        chk($sformatf("vec%0d_l2_address", idx), l2_address[0], v.addr);
        if (v.exp_write) chk($sformatf("vec%0d_l2_wdata", idx), l2_wdata[0], v.wdata);
        for (int c = 0; c < v.lat; c++) begin
            chk($sformatf("vec%0d_no_early_resp", idx), i_resp[0] || d_resp[0], 1'b0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_grant_held", idx), grant_d[0], v.exp_gd);
        end
        l2_resp[0]  = 1'b1;
        l2_rdata[0] = v.line;
        #1;
        chk($sformatf("vec%0d_i_resp", idx),  i_resp[0],  !v.use_d);
        chk($sformatf("vec%0d_d_resp", idx),  d_resp[0],  v.use_d);
        chk($sformatf("vec%0d_i_rdata", idx), i_rdata[0], v.use_d ? 128'h0 : v.line);
        chk($sformatf("vec%0d_d_rdata", idx), d_rdata[0], v.use_d ? v.line : 128'h0);
        @(posedge clk); #1;
        idle_inputs(0);
        l2_rdata[0] = v.line;
        #1;
        check_quiet(0, $sformatf("vec%0d_done", idx));
        @(posedge clk); #1;
    endtask

    // Both sides request continuously; exp bit n is the grant_d value of the n-th grant
    task automatic tie_seq(input int k, input bit [2:0] exp, input string tag);
        int cnt;
        i_address[k] = 16'h0100;
        d_address[k] = 16'h0200;
        i_read[k]    = 1'b1;
        d_read[k]    = 1'b1;
        d_write[k]   = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cnt = 0;
            while (!l2_read[k] && cnt < 8) begin
                @(posedge clk); #1;
                cnt++;
            end
            chk($sformatf("%s_wait%0d", tag, n), cnt < 8, 1'b1);
            chk($sformatf("%s_grant%0d", tag, n), grant_d[k], exp[n]);
            l2_resp[k] = 1'b1;
            @(posedge clk); #1;
            l2_resp[k] = 1'b0;
        end
        idle_inputs(k);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0;  m_gap[k] = 1'b0; m_last_d[k] = 1'b1; m_wr[k] = 1'b0;
            m_addr[k] = '0;  m_wdata[k] = '0; m_lat[k] = 0;
            i_pend[k] = 1'b0; d_pend[k] = 1'b0; i_drop[k] = 1'b0; d_drop[k] = 1'b0;
        end
    endtask

    // Random L1 and L2 behaviour for one cycle
    task automatic rand_drive(input int k);
        if (i_drop[k]) begin
            i_read[k] = 1'b0; i_pend[k] = 1'b0; i_drop[k] = 1'b0;
        end else if (!i_pend[k]) begin
            if ($urandom_range(2) == 0) begin
                i_pend[k] = 1'b1; i_read[k] = 1'b1; i_address[k] = 16'($urandom);
            end
        end else if ($urandom_range(3) == 0) begin
            i_address[k] = 16'($urandom);
        end
        if (d_drop[k]) begin
            d_read[k] = 1'b0; d_write[k] = 1'b0; d_pend[k] = 1'b0; d_drop[k] = 1'b0;
        end else if (!d_pend[k]) begin
            if ($urandom_range(2) == 0) begin
                int op;
                op = int'($urandom_range(3));
                d_pend[k]    = 1'b1;
                d_read[k]    = (op != 2);
                d_write[k]   = (op >= 2);
                d_address[k] = 16'($urandom);
                d_wdata[k]   = {$urandom, $urandom, $urandom, $urandom};
            end
        end else if ($urandom_range(3) == 0) begin
            d_address[k] = 16'($urandom);
            d_wdata[k]   = {$urandom, $urandom, $urandom, $urandom};
        end
        l2_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
        if (m_owner[k] != 0) begin
            l2_resp[k] = (m_lat[k] == 0);
            if (m_lat[k] > 0) m_lat[k]--;
        end else begin
            l2_resp[k] = ($urandom_range(7) == 0);
        end
    endtask

    // Compare against the model, then advance it across the coming clock edge
    task automatic rand_check(input int k, input int cyc);
        bit ireq, dreq, win_d, er, ew, ei, ed;
        string t;
        t  = $sformatf("rnd%0d_c%0d", k, cyc);
        er = (m_owner[k] == 1) || (m_owner[k] == 2 && !m_wr[k]);
        ew = (m_owner[k] == 2) && m_wr[k];
        ei = (m_owner[k] == 1) && l2_resp[k];
        ed = (m_owner[k] == 2) && l2_resp[k];
        chk({t, "_l2_read"},  l2_read[k],  er);
        chk({t, "_l2_write"}, l2_write[k], ew);
        chk({t, "_grant_d"},  grant_d[k],  m_owner[k] == 2);
        chk({t, "_i_resp"},   i_resp[k],   ei);
        chk({t, "_d_resp"},   d_resp[k],   ed);
        chk({t, "_i_rdata"},  i_rdata[k],  (m_owner[k] == 1) ? l2_rdata[k] : 128'h0);
        chk({t, "_d_rdata"},  d_rdata[k],  (m_owner[k] == 2) ? l2_rdata[k] : 128'h0);
        if (m_owner[k] != 0) chk({t, "_l2_address"}, l2_address[k], m_addr[k]);
        if (ew)              chk({t, "_l2_wdata"},   l2_wdata[k],   m_wdata[k]);
        if (ei) i_drop[k] = 1'b1;
        if (ed) d_drop[k] = 1'b1;
        if (m_owner[k] != 0) begin
            if (l2_resp[k]) begin
                m_last_d[k] = (m_owner[k] == 2);
                m_owner[k]  = 0;
                m_gap[k]    = 1'b1;
            end
        end else if (m_gap[k]) begin
            m_gap[k] = 1'b0;
        end else begin
            ireq = i_read[k];
            dreq = d_read[k] || d_write[k];
            if (ireq && dreq) win_d = (k == 1) ? 1'b1 : !m_last_d[k];
            else              win_d = dreq;
            if (ireq || dreq) begin
                m_owner[k] = win_d ? 2 : 1;
                m_addr[k]  = win_d ? d_address[k] : i_address[k];
                m_wr[k]    = win_d && d_write[k];
                m_wdata[k] = d_wdata[k];
                m_lat[k]   = int'($urandom_range(4));
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{use_d:1'b0, rd:1'b0, wr:1'b0, addr:16'h1230, wdata:128'h0, lat:5,
                    line:{16{8'hA5}}, exp_read:1'b1, exp_write:1'b0, exp_gd:1'b0};
        vecs[1] = '{use_d:1'b1, rd:1'b0, wr:1'b1, addr:16'h4000,
                    wdata:128'h0123456789ABCDEF0123456789ABCDEF, lat:3,
                    line:{16{8'h3C}}, exp_read:1'b0, exp_write:1'b1, exp_gd:1'b1};
        vecs[2] = '{use_d:1'b1, rd:1'b1, wr:1'b0, addr:16'h2468, wdata:128'h0, lat:0,
                    line:128'hDEADBEEFCAFEF00D0123456789ABCDEF, exp_read:1'b1, exp_write:1'b0, exp_gd:1'b1};
        vecs[3] = '{use_d:1'b1, rd:1'b1, wr:1'b1, addr:16'h7FFE, wdata:{4{32'h13579BDF}}, lat:1,
                    line:{16{8'h66}}, exp_read:1'b0, exp_write:1'b1, exp_gd:1'b1};
        vecs[4] = '{use_d:1'b0, rd:1'b0, wr:1'b0, addr:16'hFFFF, wdata:128'h0, lat:2,
                    line:{128{1'b1}}, exp_read:1'b1, exp_write:1'b0, exp_gd:1'b0};

        // reset state, with a live-looking L2 response that must be ignored
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_inputs(k);
            l2_rdata[k] = {128{1'b1}};
            l2_resp[k]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_quiet(k, $sformatf("reset%0d", k));
            chk($sformatf("reset%0d_l2_address", k), l2_address[k], 16'h0);
            chk($sformatf("reset%0d_l2_wdata", k),   l2_wdata[k],   128'h0);
            idle_inputs(k);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // repeated ties: alternation under round-robin, D always under fixed priority
        tie_seq(0, 3'b010, "tie_fair");
        tie_seq(1, 3'b111, "tie_prio");

        // lone transactions from the table
        for (int i = 0; i < 5; i++) run_entry(i, vecs[i]);

        // address change while busy must not reach the L2
        d_write[0]   = 1'b1;
        d_address[0] = 16'h4000;
        d_wdata[0]   = {4{32'hA1B2C3D4}};
        @(posedge clk); #1;
        chk("midbusy_addr_start", l2_address[0], 16'h4000);
        d_address[0] = 16'h5000;
        d_wdata[0]   = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midbusy_addr", l2_address[0], 16'h4000);
            chk("midbusy_wdata", l2_wdata[0], {4{32'hA1B2C3D4}});
            chk("midbusy_write", l2_write[0], 1'b1);
        end
        l2_resp[0] = 1'b1;
        #1;
        chk("midbusy_d_resp", d_resp[0], 1'b1);
        chk("midbusy_addr_at_resp", l2_address[0], 16'h4000);
        @(posedge clk); #1;
        idle_inputs(0);
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset while D owns the L2
        d_write[0]   = 1'b1;
        d_address[0] = 16'h4000;
        @(posedge clk); #1;
        chk("arst_pre_write", l2_write[0], 1'b1);
        chk("arst_pre_grant", grant_d[0], 1'b1);
        l2_resp[0] = 1'b1;
        #1;
        chk("arst_pre_resp", d_resp[0], 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_write", l2_write[0], 1'b0);
        chk("arst_d_resp", d_resp[0], 1'b0);
        chk("arst_grant_d", grant_d[0], 1'b0);
        chk("arst_read", l2_read[0], 1'b0);
        idle_inputs(0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        tie_seq(0, 3'b010, "tie_after_reset");

        // randomized traffic against the reference model
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) idle_inputs(k);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) rand_drive(k);
            #1;
            for (int k = 0; k < 2; k++) rand_check(k, cyc);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single unified `l2_cache` between the L1 instruction cache and the L1 data cache. It latches one L1 miss request at a time and replays it to the L2 from internal registers. It returns the L2 line and a one-cycle response to the winning requester only. Simultaneous misses are resolved round-robin. It sits between the two L1 cache `pmem_*` ports and the L2 `mem_*` port.

## Interface
- `FAIR`, default 1: 1 = round-robin between I and D; 0 = fixed D-over-I priority.
- `clk`  in  1: sole clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `i_address`  in  `lc3b_word` (16): I-cache miss address.
- `i_read`  in  1: I-cache line read request; held until `i_resp`.
- `i_rdata`  out  `lc3b_l1_line` (128): line returned to I-cache.
- `i_resp`  out  1: one-cycle completion pulse to I-cache.
- `d_address`  in  `lc3b_word` (16): D-cache miss or writeback address.
- `d_read`, `d_write`  in  1 each: D-cache requests; held until `d_resp`.
- `d_wdata`  in  `lc3b_l1_line` (128): writeback line.
- `d_rdata`  out  `lc3b_l1_line` (128): line returned to D-cache.
- `d_resp`  out  1: one-cycle completion pulse to D-cache.
- `l2_address`  out  `lc3b_word`; `l2_wdata`  out  `lc3b_l1_line`; `l2_read`, `l2_write`  out  1 each: request to L2 `mem_*`.
- `l2_rdata`  in  `lc3b_l1_line`; `l2_resp`  in  1: L2 response.
- `grant_d`  out  1: 1 while D owns the L2. Used by performance counters.

## Operation
- FSM states:
  - IDLE: no grant. Evaluate requests.
    - No request: stay in IDLE.
    - One requester: grant it.
    - Both requesters, `FAIR`=1: grant the one not served last.
    - Both requesters, `FAIR`=0: grant D.
    - On grant: latch address, wdata and op (read/write) into `req_*` registers; go to BUSY_I or BUSY_D.
  - BUSY_I / BUSY_D:
    - Drive `l2_address`, `l2_wdata`, `l2_read`/`l2_write` from the `req_*` registers.
    - On `l2_resp`: pulse the owner's `*_resp`, update the `last_d` flag, go to DONE.
  - DONE: one dead cycle with all L2 strobes low and no new grant, so the L1 caches can drop their requests. Then return to IDLE.
- `*_rdata` passes through combinationally from `l2_rdata`, but only to the owner; the non-owner sees 0.
- `*_resp` is asserted only in the cycle `l2_resp`=1 in a BUSY state.
- I requests are always reads. `l2_write` is driven only for D.
- `d_read`=`d_write`=1 is illegal. If it occurs, the arbiter forwards a write.
- Request changes while in BUSY are ignored, because replay comes from the latched registers.
- Reset values:
  - State = IDLE.
  - `last_d` = 1, so I wins the first tie.
  - All `*_resp`, `l2_read`, `l2_write` and `grant_d` = 0.
  - `req_*` registers = 0.
- Reset mid-transaction: outputs drop to 0 asynchronously. The L2 is not reset, so system reset is asserted only while the L2 is idle.

## Timing
- A request seen in IDLE at edge N is presented to the L2 from cycle N+1.
- The L1 response occurs in the same cycle as `l2_resp` (zero added return latency).
- Added overhead per transaction: 1 grant cycle + 1 DONE cycle.
- Back-to-back requests from the same requester are spaced by at least 2 idle L2 cycles.
- Ties under `FAIR`=1 alternate strictly, so neither side starves.
- Worst-case wait for a requester under `FAIR`=1 is one full foreign transaction.

## Structure
- Shared package `lc3b_types`:
  - Reuse `lc3b_word` and `lc3b_l1_line`.
  - Add `l2_arb_state_t` enum {IDLE, BUSY_I, BUSY_D, DONE}.
- One sub-module, `l2_arbiter_control`: the FSM plus `last_d`. It outputs `grant_i`/`grant_d`, `latch_req` and `done`.
- `l2_arbiter` holds the `req_*` registers and the output muxes.

## Test plan
- Lone I read of 0x1230; L2 responds after 5 cycles with line 0xA5…A5 -> `l2_read` rises 1 cycle after the request, `i_resp` is a single pulse, `i_rdata`=0xA5…A5, `d_resp` stays 0 and `d_rdata`=0.
- D write of 0x4000 with `d_wdata`=0x0123…CDEF -> `l2_write`=1, `l2_address`=0x4000, `l2_wdata` matches, `grant_d`=1 until `l2_resp`, then a DONE cycle.
- I and D request in the same cycle, three times in a row, `FAIR`=1 -> grant order I, D, I; with `FAIR`=0 -> D, D, D.
- D changes `d_address` from 0x4000 to 0x5000 mid-BUSY -> `l2_address` holds 0x4000 until the response.
- `reset_n` pulsed low mid-BUSY_D -> `l2_write`, `d_resp` and `grant_d` go to 0 immediately without waiting for `clk`; the first tie after reset goes to I.
